// File: rtl/sw_debounce_pkg.sv
// Shared I/O map constants and the switch-port width.
// Used by the switch debouncer and the I/O block.
package sw_debounce_pkg;

  localparam logic [31:0] IO_SW_ADDR   = 32'hFFFF_FFF0;
  localparam logic [31:0] IO_7SEG_ADDR = 32'hFFFF_FFF8;
  localparam int          SW_WIDTH     = 8;

  function automatic int cnt_width(input int db_cycles);
    return $clog2(db_cycles + 1);
  endfunction

endpackage

// File: rtl/sw_debounce_if.sv
// Switch-port bundle between board pins / firmware side and the debouncer.
// master drives raw pins and clear; slave is the debouncer.
interface sw_debounce_if #(
  parameter int N = 8
);

  logic [N-1:0] sw_raw;
  logic         clr_evt;
  logic [N-1:0] sw_db;
  logic [N-1:0] sw_rise;
  logic [N-1:0] sw_fall;
  logic         sw_changed;
  logic         sw_evt;

  modport master (
    output sw_raw,
    output clr_evt,
    input  sw_db,
    input  sw_rise,
    input  sw_fall,
    input  sw_changed,
    input  sw_evt
  );

  modport slave (
    input  sw_raw,
    input  clr_evt,
    output sw_db,
    output sw_rise,
    output sw_fall,
    output sw_changed,
    output sw_evt
  );

endinterface

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-flop synchroniser, stability counter,
// accepted level and registered rise/fall pulses.
module sw_debounce_bit #(
  parameter int DB_CYCLES = 50000,
  parameter int CNT_W     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             s1_q, s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_comb begin
    cnt_d  = '0;
    db_d   = db_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d   = s2_q;
        rise_d = s2_q;
        fall_d = ~s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= raw_i;
      s2_q   <= s1_q;
      cnt_q  <= cnt_d;
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign db_o   = db_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/sw_debounce.sv
// Debounced slide-switch port: N independent bits plus
// a combined change strobe and a sticky event flag for polling.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int N         = SW_WIDTH,
  parameter int DB_CYCLES = 50000
) (
  input logic              clk,
  input logic              rst,
  sw_debounce_if.slave     bus
);

  localparam int CNT_W = cnt_width(DB_CYCLES);

  logic [N-1:0] db_w, rise_w, fall_w;
  logic         chg_w;
  logic         evt_q, evt_d;

  for (genvar i = 0; i < N; i++) begin : g_bit
    sw_debounce_bit #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_bit (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (bus.sw_raw[i]),
      .db_o   (db_w[i]),
      .rise_o (rise_w[i]),
      .fall_o (fall_w[i])
    );
  end

  assign chg_w = |(rise_w | fall_w);

  // a new change wins over a simultaneous clear
  assign evt_d = chg_w | (evt_q & ~bus.clr_evt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) evt_q <= 1'b0;
    else     evt_q <= evt_d;
  end

  assign bus.sw_db      = db_w;
  assign bus.sw_rise    = rise_w;
  assign bus.sw_fall    = fall_w;
  assign bus.sw_changed = chg_w;
  assign bus.sw_evt     = evt_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce with DB_CYCLES=4 and DB_CYCLES=1.
module tb_sw_debounce;

  typedef struct {
    int         cyc;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] db;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst1 = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q0[$];
  exp_t q1[$];

  sw_debounce_if #(.N(8)) bus0 ();
  sw_debounce_if #(.N(8)) bus1 ();

  sw_debounce #(.N(8), .DB_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  sw_debounce #(.N(8), .DB_CYCLES(1)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, a, e, cyc);
    end
  endtask

  task automatic push0(input int c, input logic [7:0] r,
                       input logic [7:0] f, input logic [7:0] d);
    exp_t e;
    e.cyc = c; e.rise = r; e.fall = f; e.db = d;
    q0.push_back(e);
  endtask

  task automatic push1(input int c, input logic [7:0] r,
                       input logic [7:0] f, input logic [7:0] d);
    exp_t e;
    e.cyc = c; e.rise = r; e.fall = f; e.db = d;
    q1.push_back(e);
  endtask

  // monitors: every presented pulse must match the head of its queue
  always @(negedge clk) begin
    if (!rst && (bus0.sw_changed || |bus0.sw_rise || |bus0.sw_fall)) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL d4_unexpected: rise %0h fall %0h want none (cyc %0d)",
                 bus0.sw_rise, bus0.sw_fall, cyc);
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("d4_cyc", cyc, e.cyc);
        chk("d4_rise", {24'd0, bus0.sw_rise}, {24'd0, e.rise});
        chk("d4_fall", {24'd0, bus0.sw_fall}, {24'd0, e.fall});
        chk("d4_db", {24'd0, bus0.sw_db}, {24'd0, e.db});
        chk("d4_chg", {31'd0, bus0.sw_changed}, 32'd1);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst1 && (bus1.sw_changed || |bus1.sw_rise || |bus1.sw_fall)) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL d1_unexpected: rise %0h fall %0h want none (cyc %0d)",
                 bus1.sw_rise, bus1.sw_fall, cyc);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("d1_cyc", cyc, e.cyc);
        chk("d1_rise", {24'd0, bus1.sw_rise}, {24'd0, e.rise});
        chk("d1_fall", {24'd0, bus1.sw_fall}, {24'd0, e.fall});
        chk("d1_db", {24'd0, bus1.sw_db}, {24'd0, e.db});
      end
    end
  end

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      total++; bad++;
      $display("FAIL %s_timeout: pending %0d want 0", nm,
               q0.size() + q1.size());
      q0.delete();
      q1.delete();
    end
    @(negedge clk);
  endtask

  task automatic clear_evt();
    bus0.clr_evt = 1'b1;
    @(negedge clk);
    bus0.clr_evt = 1'b0;
  endtask

  // raw change driven at negedge c is first sampled at edge c+1,
  // so a DB-cycle debouncer accepts at edge c+2+DB
  initial begin
    int c;
    bus0.sw_raw  = 8'hFF;
    bus0.clr_evt = 1'b0;
    bus1.sw_raw  = 8'h00;
    bus1.clr_evt = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_db", {24'd0, bus0.sw_db}, 32'd0);
    chk("rst_rise", {24'd0, bus0.sw_rise}, 32'd0);
    chk("rst_evt", {31'd0, bus0.sw_evt}, 32'd0);
    c = cyc;
    rst = 1'b0;
    push0(c + 6, 8'hFF, 8'h00, 8'hFF);
    drain("t1");
    chk("t1_evt", {31'd0, bus0.sw_evt}, 32'd1);
    chk("t1_db_hold", {24'd0, bus0.sw_db}, 32'hFF);

    clear_evt();
    chk("t5_evt_clr", {31'd0, bus0.sw_evt}, 32'd0);

    c = cyc;
    bus0.sw_raw = 8'h00;
    push0(c + 6, 8'h00, 8'hFF, 8'h00);
    drain("t1b");
    clear_evt();

    bus0.sw_raw = 8'h01; @(negedge clk);
    bus0.sw_raw = 8'h00; @(negedge clk);
    bus0.sw_raw = 8'h01; @(negedge clk);
    bus0.sw_raw = 8'h00; @(negedge clk);
    c = cyc;
    bus0.sw_raw = 8'h01;
    push0(c + 6, 8'h01, 8'h00, 8'h01);
    drain("t2");
    clear_evt();

    c = cyc;
    bus0.sw_raw = 8'h00;
    push0(c + 6, 8'h00, 8'h01, 8'h00);
    drain("t3");
    clear_evt();
    chk("t4_evt_pre", {31'd0, bus0.sw_evt}, 32'd0);

    c = cyc;
    bus0.sw_raw = 8'h48;
    push0(c + 6, 8'h48, 8'h00, 8'h48);
    repeat (6) @(negedge clk);
    bus0.clr_evt = 1'b1;
    @(negedge clk);
    bus0.clr_evt = 1'b0;
    chk("t4_set_wins", {31'd0, bus0.sw_evt}, 32'd1);
    drain("t4");
    clear_evt();
    chk("t5_evt_clr2", {31'd0, bus0.sw_evt}, 32'd0);

    bus0.sw_raw = 8'h4C;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_db", {24'd0, bus0.sw_db}, 32'd0);
    chk("t6_rst_evt", {31'd0, bus0.sw_evt}, 32'd0);
    c = cyc;
    rst = 1'b0;
    push0(c + 6, 8'h4C, 8'h00, 8'h4C);
    drain("t6");

    rst1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("d1_idle_db", {24'd0, bus1.sw_db}, 32'd0);
    c = cyc;
    bus1.sw_raw = 8'h04;
    push1(c + 3, 8'h04, 8'h00, 8'h04);
    drain("t6b");
    c = cyc;
    bus1.sw_raw = 8'h00;
    push1(c + 3, 8'h00, 8'h04, 8'h00);
    drain("t6c");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
